// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall controller for the RV32I 5-stage core
// Drives pipeline register enables/flushes; tracks load stalls, memory waits and counters.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_enable,
  output logic             id_ex_flush,
  output logic             ex_mem_enable,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

  state_t            state, state_nxt, saved, saved_nxt, eff;
  logic [1:0]        cnt, cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_inc;
  logic              load_use, mem_stall, flush_evt;

  assign load_use  = ex_mem_rd && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign mem_stall = mem_req && !mem_ready;
  assign wait_inc  = (wait_cnt == {WAIT_W{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      saved <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      saved <= saved_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A release from MEM_WAIT is decided as if still in the state it interrupted.
  always_comb begin
    state_nxt     = state;
    saved_nxt     = saved;
    cnt_nxt       = cnt;
    flush_evt     = 1'b0;
    eff           = (state == MEM_WAIT) ? saved : state;
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_enable = 1'b1;
    mem_wb_flush  = 1'b0;
    if (rst) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
    end else if (mem_stall) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_flush  = 1'b1;
      if (state != MEM_WAIT) saved_nxt = state;
      state_nxt = MEM_WAIT;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_evt   = 1'b1;
      state_nxt   = RUN;
    end else if (eff == LOAD_STALL || load_use) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_ex_flush  = 1'b1;
      if (eff == LOAD_STALL) begin
        if (cnt <= 2'd1) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt   = cnt - 2'd1;
          state_nxt = LOAD_STALL;
        end
      end else if (LOAD_STALL_CYCLES > 1) begin
        cnt_nxt   = STALL_INIT;
        state_nxt = LOAD_STALL;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      if (!pc_enable && stall_cycles != {CNT_W{1'b1}}) stall_cycles <= stall_cycles + 1'b1;
      if (flush_evt && flush_count != {CNT_W{1'b1}}) flush_count <= flush_count + 1'b1;
      if (mem_stall) begin
        wait_cnt <= wait_inc;
        if (wait_inc >= TIMEOUT_V) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed bench for hazard_ctrl with LOAD_STALL_CYCLES of 1, 2 and 3
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_rd, branch_taken, mem_req, mem_ready;
  logic pc_en [3];
  logic ife [3];
  logic iff_ [3];
  logic ide [3];
  logic idf [3];
  logic exe [3];
  logic mwf [3];
  logic tmo [3];
  logic [31:0] sc [3];
  logic [31:0] fc [3];
  int checks = 0;
  int failures = 0;

  // {pc, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, mem_wb_fl}
  localparam logic [6:0] C_NORM  = 7'b1101010;
  localparam logic [6:0] C_MEM   = 7'b0000001;
  localparam logic [6:0] C_BR    = 7'b1111110;
  localparam logic [6:0] C_STALL = 7'b0001110;
  localparam logic [6:0] C_RST   = 7'b0000000;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(.LOAD_STALL_CYCLES(g + 1), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_rd(ex_mem_rd), .branch_taken(branch_taken), .mem_req(mem_req),
      .mem_ready(mem_ready), .pc_enable(pc_en[g]), .if_id_enable(ife[g]),
      .if_id_flush(iff_[g]), .id_ex_enable(ide[g]), .id_ex_flush(idf[g]),
      .ex_mem_enable(exe[g]), .mem_wb_flush(mwf[g]), .stall_cycles(sc[g]),
      .flush_count(fc[g]), .mem_timeout(tmo[g])
    );
  end

  function automatic logic [6:0] ctl(int i);
    return {pc_en[i], ife[i], iff_[i], ide[i], idf[i], exe[i], mwf[i]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_rd = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic hazard_rs1();
    ex_mem_rd = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    #2;
    chk("rst_ctl0", 32'(ctl(0)), 32'(C_RST));
    chk("rst_ctl2", 32'(ctl(2)), 32'(C_RST));
    chk("rst_sc0", sc[0], 0);
    chk("rst_fc0", fc[0], 0);
    chk("rst_tmo0", 32'(tmo[0]), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("idle_norm", 32'(ctl(0)), 32'(C_NORM));

    // Single-cycle load-use stall
    hazard_rs1();
    #1;
    chk("lu_stall_l1", 32'(ctl(0)), 32'(C_STALL));
    tick();
    clear_in();
    #1;
    chk("lu_after_l1", 32'(ctl(0)), 32'(C_NORM));
    chk("lu_sc_l1", sc[0], 1);

    // Masked / non-matching hazards
    do_reset();
    ex_mem_rd = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1;
    chk("rd0_nostall", 32'(ctl(0)), 32'(C_NORM));
    ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b0;
    #1;
    chk("uses0_nostall", 32'(ctl(0)), 32'(C_NORM));
    ex_mem_rd = 1'b0; id_uses_rs1 = 1'b1;
    #1;
    chk("noload_nostall", 32'(ctl(0)), 32'(C_NORM));
    ex_mem_rd = 1'b1; id_uses_rs1 = 1'b0; id_rs1 = 5'd1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    #1;
    chk("rs2_stall", 32'(ctl(0)), 32'(C_STALL));
    tick();
    clear_in();

    // Branch beats load-use
    do_reset();
    hazard_rs1();
    branch_taken = 1'b1;
    #1;
    chk("br_ctl_l1", 32'(ctl(0)), 32'(C_BR));
    chk("br_ctl_l2", 32'(ctl(1)), 32'(C_BR));
    tick();
    clear_in();
    #1;
    chk("br_fc", fc[0], 1);
    chk("br_sc", sc[0], 0);
    chk("br_after_l2", 32'(ctl(1)), 32'(C_NORM));

    // LOAD_STALL_CYCLES=2 with a memory wait inside the second stall cycle
    do_reset();
    hazard_rs1();
    #1;
    chk("mw_stall1", 32'(ctl(1)), 32'(C_STALL));
    tick();
    clear_in();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_frozen%0d", i), 32'(ctl(1)), 32'(C_MEM));
      tick();
    end
    mem_req = 1'b0;
    #1;
    chk("mw_resume_l2", 32'(ctl(1)), 32'(C_STALL));
    chk("mw_resume_l1", 32'(ctl(0)), 32'(C_NORM));
    tick();
    #1;
    chk("mw_done_l2", 32'(ctl(1)), 32'(C_NORM));
    chk("mw_sc_l2", sc[1], 5);
    chk("mw_sc_l1", sc[0], 4);

    // Memory timeout at 4 wait cycles, sticky until reset
    do_reset();
    mem_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("tmo_cyc%0d", i), 32'(tmo[0]), (i >= 4) ? 1 : 0);
    end
    mem_ready = 1'b1;
    #1;
    chk("tmo_release_ctl", 32'(ctl(0)), 32'(C_NORM));
    tick();
    chk("tmo_sticky", 32'(tmo[0]), 1);
    chk("tmo_sc", sc[0], 6);
    do_reset();
    #1;
    chk("tmo_cleared", 32'(tmo[0]), 0);

    // Async reset during LOAD_STALL with LOAD_STALL_CYCLES=3
    hazard_rs1();
    tick();
    clear_in();
    #1;
    chk("ar_in_stall", 32'(ctl(2)), 32'(C_STALL));
    chk("ar_sc_before", sc[2], 1);
    rst = 1'b1;
    #1;
    chk("ar_ctl_now", 32'(ctl(2)), 32'(C_RST));
    chk("ar_sc_now", sc[2], 0);
    tick();
    rst = 1'b0;
    #1;
    chk("ar_run_after", 32'(ctl(2)), 32'(C_NORM));
    tick();
    chk("ar_sc_after", sc[2], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
